acq_mem_arbiter: RTL and testbench

- Sequences the single-port acquisition RAM used as a byte FIFO between the DiscReader write stream and the host readback port.
- Owns the write/read pointers, fill count and full/empty/overflow/underflow status; arbitrates RAM port access between the two requesters.
- Sits between the DiscReader core (producer) and the microcontroller bus interface (consumer); the RAM itself is external to this block.

---
 rtl/acq_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_acq_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_mem_arbiter.sv
// acq_mem_arbiter: runs a single-port acquisition RAM as a byte FIFO.
// The DiscReader writes into it and the host reads it back. The block owns the
// read/write pointers, the fill count and the status flags, and decides which
// requester gets the RAM port.
//
// Optional feature: define ACQ_MEM_ARBITER_CHECKSUM_EN to add a 32-bit running
// sum of every byte delivered to the host.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   flush               synchronous clear of FIFO state
//   acq_wr_req/data/ack producer write handshake (ack is a one-cycle pulse)
//   host_rd_req/data/valid
//                       consumer read handshake (valid is a one-cycle pulse)
//   ram_addr/wdata/we/rd/rdata
//                       external single-port RAM; read data arrives one cycle after ram_rd
//   count, empty, full  fill level and derived flags
//   overflow, underflow sticky error flags
//   checksum            (only with ACQ_MEM_ARBITER_CHECKSUM_EN) sum of delivered bytes
module acq_mem_arbiter #(
    parameter int unsigned ADDR_W        = 3,
    parameter int unsigned HOST_MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              acq_wr_req,
    input  logic [7:0]        acq_wr_data,
    output logic              acq_wr_ack,
    input  logic              host_rd_req,
    output logic [7:0]        host_rd_data,
    output logic              host_rd_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    output logic              ram_rd,
    input  logic [7:0]        ram_rdata,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
`ifdef ACQ_MEM_ARBITER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [3:0]  WAIT_LIMIT = 4'(HOST_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wrptr;
    logic [ADDR_W-1:0] rdptr;
    logic [3:0]        host_wait;

    // A host request seen while its valid pulse is still out is the request
    // that was just served, so it is ignored for that one cycle.
    logic host_req_eff;
    assign host_req_eff = host_rd_req & ~host_rd_valid;

    // FSM, pointers, count, flags and RAM strobes, all registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wrptr         <= '0;
            rdptr         <= '0;
            host_wait     <= '0;
            count         <= '0;
            empty         <= 1'b1;
            full          <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            acq_wr_ack    <= 1'b0;
            host_rd_data  <= '0;
            host_rd_valid <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_we        <= 1'b0;
            ram_rd        <= 1'b0;
`ifdef ACQ_MEM_ARBITER_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            // Strobes and pulses default low every cycle.
            acq_wr_ack    <= 1'b0;
            host_rd_valid <= 1'b0;
            ram_we        <= 1'b0;
            ram_rd        <= 1'b0;

            if (flush) begin
                // Abort everything; an in-flight read never produces valid.
                state     <= IDLE;
                wrptr     <= '0;
                rdptr     <= '0;
                host_wait <= '0;
                count     <= '0;
                empty     <= 1'b1;
                full      <= 1'b0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
`ifdef ACQ_MEM_ARBITER_CHECKSUM_EN
                checksum  <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        // Actions for the granted state are registered on entry,
                        // so the strobes are visible during that state's cycle.
                        if (acq_wr_req && !(host_req_eff && host_wait == WAIT_LIMIT)) begin
                            if (host_req_eff && host_wait != 4'd15) begin
                                host_wait <= host_wait + 4'd1;
                            end
                            state      <= WR;
                            acq_wr_ack <= 1'b1;
                            if (!full) begin
                                ram_we    <= 1'b1;
                                ram_addr  <= wrptr;
                                ram_wdata <= acq_wr_data;
                                wrptr     <= wrptr + ADDR_W'(1);
                                count     <= count + CNT_W'(1);
                                empty     <= 1'b0;
                                full      <= (count == CNT_W'(DEPTH - 1));
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (host_req_eff) begin
                            host_wait <= '0;
                            state     <= RD_ADDR;
                            if (!empty) begin
                                ram_rd   <= 1'b1;
                                ram_addr <= rdptr;
                                rdptr    <= rdptr + ADDR_W'(1);
                                count    <= count - CNT_W'(1);
                                full     <= 1'b0;
                                empty    <= (count == CNT_W'(1));
                            end
                        end
                    end

                    WR: begin
                        state <= IDLE;
                    end

                    RD_ADDR: begin
                        // ram_rd still high means a real read was issued on entry.
                        if (ram_rd) begin
                            state <= RD_DATA;
                        end else begin
                            underflow     <= 1'b1;
                            host_rd_data  <= 8'h00;
                            host_rd_valid <= 1'b1;
                            state         <= IDLE;
                        end
                    end

                    RD_DATA: begin
                        host_rd_data  <= ram_rdata;
                        host_rd_valid <= 1'b1;
`ifdef ACQ_MEM_ARBITER_CHECKSUM_EN
                        checksum      <= checksum + 32'(ram_rdata);
`endif
                        state         <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_mem_arbiter.sv
// Directed bench for acq_mem_arbiter with a behavioural single-port RAM.
module tb_acq_mem_arbiter;

    logic       clock;
    logic       reset;
    logic       flush;
    logic       acq_wr_req;
    logic [7:0] acq_wr_data;
    logic       acq_wr_ack;
    logic       host_rd_req;
    logic [7:0] host_rd_data;
    logic       host_rd_valid;
    logic [2:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic       ram_rd;
    logic [7:0] ram_rdata;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;
`ifdef ACQ_MEM_ARBITER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    acq_mem_arbiter #(.ADDR_W(3), .HOST_MAX_WAIT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .acq_wr_req   (acq_wr_req),
        .acq_wr_data  (acq_wr_data),
        .acq_wr_ack   (acq_wr_ack),
        .host_rd_req  (host_rd_req),
        .host_rd_data (host_rd_data),
        .host_rd_valid(host_rd_valid),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rd       (ram_rd),
        .ram_rdata    (ram_rdata),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef ACQ_MEM_ARBITER_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM: synchronous write, registered read.
    logic [7:0] mem [8];
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One producer write; returns the RAM strobe/address seen with the ack and cycles to ack.
    task automatic do_write(input logic [7:0] d, output logic we, output logic [2:0] addr, output int lat);
        int n;
        @(negedge clock);
        acq_wr_req  = 1'b1;
        acq_wr_data = d;
        n = 0;
        while (!acq_wr_ack && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("wr_ack_seen", 32'(acq_wr_ack), 32'd1);
        we   = ram_we;
        addr = ram_addr;
        lat  = n;
        acq_wr_req = 1'b0;
    endtask

    // One host read; returns data and cycles to valid.
    task automatic do_read(output logic [7:0] d, output int lat);
        int n;
        @(negedge clock);
        host_rd_req = 1'b1;
        n = 0;
        while (!host_rd_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("rd_valid_seen", 32'(host_rd_valid), 32'd1);
        d   = host_rd_data;
        lat = n;
        host_rd_req = 1'b0;
    endtask

    initial begin
        logic       we;
        logic [2:0] addr;
        logic [7:0] d;
        int         lat;
        int         acks_before;
        int         acks_after;
        int         valids;
        int         n;
        logic [7:0] host_byte;
        logic       seen_valid;
        logic       late_valid;

        reset       = 1'b0;
        flush       = 1'b0;
        acq_wr_req  = 1'b0;
        acq_wr_data = 8'h00;
        host_rd_req = 1'b0;

        // Reset values.
        repeat (2) @(negedge clock);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_ack", 32'(acq_wr_ack), 32'd0);
        check("rst_valid", 32'(host_rd_valid), 32'd0);
        check("rst_we_rd", {30'd0, ram_we, ram_rd}, 32'd0);
        check("rst_rd_data", 32'(host_rd_data), 32'd0);
        reset = 1'b1;

        // Five writes of 0x6F, then five reads.
        for (int i = 0; i < 5; i++) begin
            do_write(8'h6F, we, addr, lat);
            check("w5_we", 32'(we), 32'd1);
            check("w5_addr", 32'(addr), 32'(i));
            if (i == 0) check("w5_latency", 32'(lat), 32'd1);
        end
        @(negedge clock);
        check("w5_count", 32'(count), 32'd5);
        check("w5_empty", 32'(empty), 32'd0);
        check("w5_full", 32'(full), 32'd0);
        for (int i = 0; i < 5; i++) check("w5_ram", 32'(mem[i]), 32'h6F);
        for (int i = 0; i < 5; i++) begin
            do_read(d, lat);
            check("r5_data", 32'(d), 32'h6F);
            if (i == 0) check("r5_latency", 32'(lat), 32'd3);
        end
        check("r5_empty", 32'(empty), 32'd1);
        check("r5_count", 32'(count), 32'd0);
`ifdef ACQ_MEM_ARBITER_CHECKSUM_EN
        check("r5_checksum", checksum, 32'd555);
`endif

        // Read while empty: zero byte, underflow, pointers untouched.
        do_read(d, lat);
        check("uf_data", 32'(d), 32'h00);
        check("uf_latency", 32'(lat), 32'd2);
        check("uf_flag", 32'(underflow), 32'd1);
        check("uf_count", 32'(count), 32'd0);

        // Wrap: write 8 (addr 5..7,0..4), read 6, write 6 more, read all 8 back.
        for (int i = 0; i < 8; i++) begin
            do_write(8'(8'hA0 + i), we, addr, lat);
            check("wrap_addr1", 32'(addr), 32'((5 + i) % 8));
        end
        @(negedge clock);
        check("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 6; i++) begin
            do_read(d, lat);
            check("wrap_rd1", 32'(d), 32'(8'hA0 + i));
        end
        for (int i = 0; i < 6; i++) begin
            do_write(8'(8'h10 + i), we, addr, lat);
            check("wrap_addr2", 32'(addr), 32'((5 + i) % 8));
        end
        @(negedge clock);
        check("wrap_count", 32'(count), 32'd8);
        do_read(d, lat);
        check("wrap_old0", 32'(d), 32'hA6);
        do_read(d, lat);
        check("wrap_old1", 32'(d), 32'hA7);
        for (int i = 0; i < 6; i++) begin
            do_read(d, lat);
            check("wrap_new", 32'(d), 32'(8'h10 + i));
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Nine writes into an empty FIFO: eight stored, ninth acked but dropped.
        for (int i = 0; i < 9; i++) begin
            do_write(8'(8'hC0 + i), we, addr, lat);
            check("ovf_we", 32'(we), (i < 8) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);

        // Flush while a read sits in RD_DATA.
        @(negedge clock);
        host_rd_req = 1'b1;
        @(negedge clock);
        check("fl_ram_rd", 32'(ram_rd), 32'd1);
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        host_rd_req = 1'b0;
        check("fl_valid", 32'(host_rd_valid), 32'd0);
        check("fl_count", 32'(count), 32'd0);
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_full", 32'(full), 32'd0);
        check("fl_flags", {30'd0, overflow, underflow}, 32'd0);
`ifdef ACQ_MEM_ARBITER_CHECKSUM_EN
        check("fl_checksum", checksum, 32'd0);
`endif
        late_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (host_rd_valid) late_valid = 1'b1;
        end
        check("fl_no_valid", 32'(late_valid), 32'd0);

        // Both requesters held: four write grants, then the host, then writes again.
        @(negedge clock);
        acq_wr_data = 8'h55;
        acq_wr_req  = 1'b1;
        host_rd_req = 1'b1;
        acks_before = 0;
        acks_after  = 0;
        valids      = 0;
        seen_valid  = 1'b0;
        host_byte   = 8'h00;
        n = 0;
        while (acks_after < 2 && n < 60) begin
            @(negedge clock);
            n++;
            if (acq_wr_ack) begin
                if (seen_valid) acks_after++;
                else acks_before++;
            end
            if (host_rd_valid) begin
                valids++;
                seen_valid = 1'b1;
                host_byte  = host_rd_data;
            end
        end
        acq_wr_req  = 1'b0;
        host_rd_req = 1'b0;
        check("arb_done", 32'(acks_after), 32'd2);
        check("arb_wr_before_host", 32'(acks_before), 32'd4);
        check("arb_host_grants", 32'(valids), 32'd1);
        check("arb_host_data", 32'(host_byte), 32'h55);
        repeat (2) @(negedge clock);
        check("arb_count", 32'(count), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
